// File: rtl/iir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iir_pkg
// Purpose  : Shared types, coefficient indices and sample reduction helpers
//            for the biquad cascade.
// Revision : 1.0 - initial release
// ============================================================================
package iir_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_MAC   = 3'd2,
      S_STORE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam int NTAPS = 5;
   localparam logic [2:0] K_B0 = 3'd0;
   localparam logic [2:0] K_B1 = 3'd1;
   localparam logic [2:0] K_B2 = 3'd2;
   localparam logic [2:0] K_A1 = 3'd3;
   localparam logic [2:0] K_A2 = 3'd4;

   // Passthrough coefficient set: b0 = 1.0 in the coefficient format, rest 0.
   function automatic longint pass_coef(input int k, input int cfrac);
      longint v;
      v = 64'sd0;
      if (k == int'(K_B0))
         v = 64'sd1 <<< cfrac;
      return v;
   endfunction

   function automatic longint reduce_dw(input longint v, input int dw, input bit sat);
      longint hi;
      longint lo;
      longint r;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (dw - 1));
      r  = v;
      if (sat) begin
         if (v > hi)
            r = hi;
         else if (v < lo)
            r = lo;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/iir_mac.sv
`default_nettype none
// ============================================================================
// Module   : iir_mac
// Purpose  : Signed multiply-accumulate with clear/subtract, result >>> CFRAC.
// Revision : 1.0 - initial release
// ============================================================================
module iir_mac #(
   parameter int CW    = 16,
   parameter int DW    = 16,
   parameter int ACCW  = 40,
   parameter int CFRAC = 14
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en_i,
   input  logic                   clr_i,
   input  logic                   sub_i,
   input  logic signed [CW-1:0]   coef_i,
   input  logic signed [DW-1:0]   data_i,
   output logic signed [ACCW-1:0] res_o
);

   localparam int PW = CW + DW;

   logic signed [PW-1:0]   a_ext;
   logic signed [PW-1:0]   b_ext;
   logic signed [PW-1:0]   prod;
   logic signed [ACCW-1:0] term;
   logic signed [ACCW-1:0] sum;
   logic signed [ACCW-1:0] acc_q;

   assign a_ext = {{DW{coef_i[CW-1]}}, coef_i};
   assign b_ext = {{CW{data_i[DW-1]}}, data_i};
   assign prod  = a_ext * b_ext;
   assign term  = {{(ACCW-PW){prod[PW-1]}}, prod};
   // Result is taken from the running sum so the section output is ready on its last tap.
   assign sum   = (clr_i ? '0 : acc_q) + (sub_i ? -term : term);
   assign res_o = sum >>> CFRAC;

   always_ff @(posedge clk) begin
      if (rst)
         acc_q <= '0;
      else if (en_i)
         acc_q <= sum;
   end

endmodule
`default_nettype wire

// File: rtl/iir_biquad_cascade.sv
`default_nettype none
// ============================================================================
// Module   : iir_biquad_cascade
// Purpose  : NSEC-section DF-I biquad cascade on one shared MAC; IIR_SAT_EN
//            selects saturating instead of wrapping section results.
// Revision : 1.0 - initial release
// ============================================================================
module iir_biquad_cascade
   import iir_pkg::*;
#(
   parameter int DW    = 16,
   parameter int CW    = 16,
   parameter int CFRAC = 14,
   parameter int NSEC  = 3,
   parameter int AW    = 20,
   parameter int ACCW  = 40
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         data_done,
   output logic                         load,
   output logic [AW-1:0]                RAddr,
   input  logic signed [DW-1:0]         DIn,
   output logic                         WEN,
   output logic [AW-1:0]                WAddr,
   output logic signed [DW-1:0]         Yn,
   output logic                         Finish,
   output logic                         busy,
   input  logic                         coef_we,
   input  logic [$clog2(5*NSEC)-1:0]    coef_addr,
   input  logic signed [CW-1:0]         coef_wdata
);

   localparam int NC   = NTAPS * NSEC;
   localparam int CAW  = $clog2(NC);
   localparam int SECW = (NSEC > 1) ? $clog2(NSEC) : 1;
`ifdef IIR_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   state_t                state_q, state_d;
   logic [CAW-1:0]        cidx_q;
   logic [2:0]            k_q;
   logic [SECW-1:0]       sec_q;
   logic signed [CW-1:0]  coef_q [NC];
   logic signed [DW-1:0]  x1_q [NSEC];
   logic signed [DW-1:0]  x2_q [NSEC];
   logic signed [DW-1:0]  y1_q [NSEC];
   logic signed [DW-1:0]  y2_q [NSEC];
   logic signed [DW-1:0]  xin_q;
   logic [AW-1:0]         raddr_q, waddr_q;
   logic signed [DW-1:0]  yn_q;
   logic signed [DW-1:0]  mac_data, r_val;
   logic signed [ACCW-1:0] mac_res;
   logic                  mac_en, sec_end, last_tap, idle_like;

   assign mac_en    = (state_q == S_MAC);
   assign sec_end   = mac_en && (k_q == K_A2);
   assign last_tap  = mac_en && (cidx_q == CAW'(NC - 1));
   assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
   assign RAddr     = raddr_q;
   assign WAddr     = waddr_q;
   assign Yn        = yn_q;

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      WEN     = 1'b0;
      Finish  = 1'b0;
      busy    = 1'b0;
      case (state_q)
         S_IDLE:  if (start) state_d = S_FETCH;
         S_FETCH: begin
            busy    = 1'b1;
            load    = !data_done;
            state_d = data_done ? S_DONE : S_MAC;
         end
         S_MAC: begin
            busy = 1'b1;
            if (last_tap) state_d = S_STORE;
         end
         S_STORE: begin
            busy    = 1'b1;
            WEN     = !rst;
            state_d = S_FETCH;
         end
         S_DONE: begin
            Finish = 1'b1;
            if (start) state_d = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mac_data = xin_q;
      case (k_q)
         K_B0:    mac_data = (sec_q == '0) ? DIn : xin_q;
         K_B1:    mac_data = x1_q[sec_q];
         K_B2:    mac_data = x2_q[sec_q];
         K_A1:    mac_data = y1_q[sec_q];
         K_A2:    mac_data = y2_q[sec_q];
         default: mac_data = xin_q;
      endcase
   end

   iir_mac #(
      .CW    (CW),
      .DW    (DW),
      .ACCW  (ACCW),
      .CFRAC (CFRAC)
   ) u_mac (
      .clk    (clk),
      .rst    (rst),
      .en_i   (mac_en),
      .clr_i  (k_q == K_B0),
      .sub_i  ((k_q == K_A1) || (k_q == K_A2)),
      .coef_i (coef_q[cidx_q]),
      .data_i (mac_data),
      .res_o  (mac_res)
   );

   assign r_val = DW'(reduce_dw({{(64-ACCW){mac_res[ACCW-1]}}, mac_res}, DW, SAT));

   always_ff @(posedge clk) begin
      if (rst) begin
         cidx_q  <= '0;
         k_q     <= '0;
         sec_q   <= '0;
         xin_q   <= '0;
         raddr_q <= '0;
         waddr_q <= '0;
         yn_q    <= '0;
         for (int i = 0; i < NC; i++)
            coef_q[i] <= CW'(pass_coef(i % NTAPS, CFRAC));
         for (int s = 0; s < NSEC; s++) begin
            x1_q[s] <= '0;
            x2_q[s] <= '0;
            y1_q[s] <= '0;
            y2_q[s] <= '0;
         end
      end else begin
         if (coef_we && idle_like && (coef_addr < CAW'(NC)))
            coef_q[coef_addr] <= coef_wdata;

         if (idle_like && start) begin
            cidx_q  <= '0;
            k_q     <= '0;
            sec_q   <= '0;
            raddr_q <= '0;
            for (int s = 0; s < NSEC; s++) begin
               x1_q[s] <= '0;
               x2_q[s] <= '0;
               y1_q[s] <= '0;
               y2_q[s] <= '0;
            end
         end

         if (mac_en) begin
            cidx_q <= cidx_q + CAW'(1);
            k_q    <= k_q + 3'd1;
            if ((k_q == K_B0) && (sec_q == '0))
               xin_q <= DIn;
            // Section boundary: shift history; the result becomes the next section's input.
            if (sec_end) begin
               x2_q[sec_q] <= x1_q[sec_q];
               x1_q[sec_q] <= xin_q;
               y2_q[sec_q] <= y1_q[sec_q];
               y1_q[sec_q] <= r_val;
               xin_q       <= r_val;
               k_q         <= '0;
               sec_q       <= sec_q + SECW'(1);
            end
            if (last_tap) begin
               cidx_q  <= '0;
               sec_q   <= '0;
               yn_q    <= r_val;
               waddr_q <= raddr_q;
            end
         end

         if (state_q == S_STORE)
            raddr_q <= raddr_q + AW'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_iir_biquad_cascade.sv
`default_nettype none
// ============================================================================
// Module   : tb_iir_biquad_cascade
// Purpose  : Self-checking bench: sample-level DF-I reference model plus
//            literal expectations for the biquad cascade.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_iir_biquad_cascade;

   localparam int DW    = 16;
   localparam int CW    = 16;
   localparam int CFRAC = 14;
   localparam int NSEC  = 3;
   localparam int AW    = 20;
   localparam int ACCW  = 40;
   localparam int NC    = 5 * NSEC;
   localparam int CAW   = $clog2(NC);
   localparam int PER   = 5 * NSEC + 2;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  start = 1'b0;
   logic                  data_done = 1'b0;
   logic                  load, WEN, Finish, busy;
   logic [AW-1:0]         RAddr, WAddr;
   logic signed [DW-1:0]  DIn = '0;
   logic signed [DW-1:0]  Yn;
   logic                  coef_we = 1'b0;
   logic [CAW-1:0]        coef_addr = '0;
   logic signed [CW-1:0]  coef_wdata = '0;

   iir_biquad_cascade #(
      .DW(DW), .CW(CW), .CFRAC(CFRAC), .NSEC(NSEC), .AW(AW), .ACCW(ACCW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .data_done(data_done),
      .load(load), .RAddr(RAddr), .DIn(DIn), .WEN(WEN), .WAddr(WAddr),
      .Yn(Yn), .Finish(Finish), .busy(busy), .coef_we(coef_we),
      .coef_addr(coef_addr), .coef_wdata(coef_wdata)
   );

   always #5 clk = ~clk;

   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // reference model state
   longint mc [NC];
   longint mx1 [NSEC], mx2 [NSEC], my1 [NSEC], my2 [NSEC];
   longint mem [64];
   longint obs [64];
   int     nsamp = 0;
   int     exp_idx = 0;
   int     wen_cnt = 0;
   longint last_load = 0;
   longint last_wen = 0;

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic longint red(input longint v);
      longint full, half, m;
      full = 64'sd1 <<< DW;
      half = 64'sd1 <<< (DW - 1);
`ifdef IIR_SAT_EN
      m = v;
      if (v > half - 1) m = half - 1;
      if (v < -half)    m = -half;
`else
      m = v & (full - 1);
      if (m >= half) m = m - full;
`endif
      return m;
   endfunction

   task automatic model_step(input longint xin, output longint y);
      longint x, acc, r;
      x = xin;
      for (int s = 0; s < NSEC; s++) begin
         acc = mc[5*s] * x + mc[5*s+1] * mx1[s] + mc[5*s+2] * mx2[s]
             - mc[5*s+3] * my1[s] - mc[5*s+4] * my2[s];
         r = red(acc >>> CFRAC);
         mx2[s] = mx1[s]; mx1[s] = x;
         my2[s] = my1[s]; my1[s] = r;
         x = r;
      end
      y = x;
   endtask

   task automatic model_clear();
      for (int s = 0; s < NSEC; s++) begin
         mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
      end
      for (int i = 0; i < 64; i++) obs[i] = 99999;
      exp_idx = 0;
      wen_cnt = 0;
   endtask

   task automatic model_pass();
      for (int i = 0; i < NC; i++) mc[i] = (i % 5 == 0) ? (64'sd1 <<< CFRAC) : 64'sd0;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 64; i++) mem[i] = 0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wcoef(input int idx, input longint val, input bit with_start);
      coef_we    = 1'b1;
      coef_addr  = CAW'(idx);
      coef_wdata = CW'(val);
      start      = with_start;
      mc[idx]    = coef_wdata;
      if (with_start) model_clear();
      @(negedge clk);
      coef_we = 1'b0;
      start   = 1'b0;
   endtask

   task automatic do_start();
      model_clear();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_finish(input string name, input int n);
      int k;
      k = 0;
      while (!Finish && k < 4000) begin
         @(negedge clk);
         k++;
      end
      chk({name, " finish"}, Finish, 1);
      tick(3);
      chk({name, " finish held"}, Finish, 1);
      chk({name, " busy low"}, busy, 0);
      chk({name, " wen count"}, wen_cnt, n);
   endtask

   task automatic run(input string name, input int n);
      nsamp = n;
      do_start();
      wait_finish(name, n);
   endtask

   // sample ROM and end-of-stream flag
   initial forever begin
      @(negedge clk);
      data_done = (int'(RAddr) >= nsamp);
      if (int'(RAddr) < 64) DIn = DW'(mem[int'(RAddr)]);
   end

   // output compare against the reference model on every write strobe
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (load) last_load = cyc;
         if (WEN) begin
            longint y;
            model_step((exp_idx < 64) ? mem[exp_idx] : 64'sd0, y);
            chk("Yn", Yn, y);
            chk("WAddr", WAddr, exp_idx);
            chk("latency", cyc - last_load, 5 * NSEC + 1);
            if (wen_cnt > 0) chk("spacing", cyc - last_wen, PER);
            if (exp_idx < 64) obs[exp_idx] = Yn;
            last_wen = cyc;
            exp_idx++;
            wen_cnt++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

   initial begin
      model_pass();
      model_clear();
      clear_mem();
      rst = 1'b1;
      tick(2);
      chk("rst load", load, 0);
      chk("rst WEN", WEN, 0);
      chk("rst Finish", Finish, 0);
      chk("rst busy", busy, 0);
      chk("rst RAddr", RAddr, 0);
      chk("rst WAddr", WAddr, 0);
      chk("rst Yn", Yn, 0);
      rst = 1'b0;
      tick(1);

      // passthrough cascade
      mem[0] = 100; mem[1] = -200; mem[2] = 32767;
      run("t1", 3);
      chk("t1 y0", obs[0], 100);
      chk("t1 y1", obs[1], -200);
      chk("t1 y2", obs[2], 32767);

      // b0 = 0.5 with floor rounding
      clear_mem();
      wcoef(0, 8192, 1'b0);
      mem[0] = 1000; mem[1] = -3;
      run("t2", 2);
      chk("t2 y0", obs[0], 500);
      chk("t2 y1", obs[1], -2);

      // single-pole recursion y = x + 0.5*y1
      clear_mem();
      wcoef(0, 16384, 1'b0);
      wcoef(3, -8192, 1'b0);
      mem[0] = 16384;
      run("t3", 5);
      chk("t3 y0", obs[0], 16384);
      chk("t3 y1", obs[1], 8192);
      chk("t3 y2", obs[2], 4096);
      chk("t3 y3", obs[3], 2048);
      chk("t3 y4", obs[4], 1024);

      // overflow: coefficient written in the same cycle as start
      clear_mem();
      wcoef(3, 0, 1'b0);
      mem[0] = 30000;
      nsamp = 1;
      wcoef(0, 24576, 1'b1);
      wait_finish("t4", 1);
`ifdef IIR_SAT_EN
      chk("t4 y0", obs[0], 32767);
`else
      chk("t4 y0", obs[0], -20536);
`endif

      // writes and start while busy are ignored; restart from DONE
      clear_mem();
      wcoef(0, 16384, 1'b0);
      for (int i = 0; i < 4; i++) mem[i] = longint'($urandom_range(0, 65535)) - 32768;
      nsamp = 4;
      do_start();
      tick(5);
      chk("t5 busy", busy, 1);
      coef_we = 1'b1; coef_addr = '0; coef_wdata = '0; start = 1'b1;
      @(negedge clk);
      coef_we = 1'b0; start = 1'b0;
      wait_finish("t5a", 4);
      for (int i = 0; i < 4; i++) chk("t5 pass", obs[i], mem[i]);
      model_clear();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("t5 finish drop", Finish, 0);
      chk("t5 busy rise", busy, 1);
      wait_finish("t5b", 4);
      chk("t5 restart y0", obs[0], mem[0]);

      // random coefficients and samples against the model
      for (int i = 0; i < NC; i++) wcoef(i, longint'($urandom_range(0, 65535)) - 32768, 1'b0);
      clear_mem();
      for (int i = 0; i < 12; i++) mem[i] = longint'($urandom_range(0, 65535)) - 32768;
      run("t6", 12);

      // reset in the middle of the second sample
      nsamp = 4;
      do_start();
      begin
         int k;
         k = 0;
         while (wen_cnt < 1 && k < 200) begin
            @(negedge clk);
            k++;
         end
         chk("t7 first write", wen_cnt, 1);
      end
      tick(5);
      rst = 1'b1;
      tick(1);
      chk("t7 WEN", WEN, 0);
      chk("t7 load", load, 0);
      chk("t7 Finish", Finish, 0);
      chk("t7 busy", busy, 0);
      chk("t7 RAddr", RAddr, 0);
      chk("t7 WAddr", WAddr, 0);
      chk("t7 Yn", Yn, 0);
      chk("t7 no partial write", wen_cnt, 1);
      rst = 1'b0;
      model_pass();
      tick(1);
      clear_mem();
      for (int i = 0; i < 3; i++) mem[i] = longint'($urandom_range(0, 65535)) - 32768;
      run("t7", 3);
      for (int i = 0; i < 3; i++) chk("t7 pass", obs[i], mem[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
